// File: rtl/ets_frame_packer_if.sv
`default_nettype none
// ============================================================================
//  Module      : ets_frame_packer_if
//  Description : Sample-input and AXI-Stream-output handshake bundle for the
//                ETS frame packer. The master modport is the packer side; the
//                slave modport is the sample source / stream sink side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ets_frame_packer_if;

    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;

    modport master (
        input  s_data,
        input  s_valid,
        output s_ready,
        output m_axis_tdata,
        output m_axis_tvalid,
        input  m_axis_tready,
        output m_axis_tlast
    );

    modport slave (
        output s_data,
        output s_valid,
        input  s_ready,
        input  m_axis_tdata,
        input  m_axis_tvalid,
        output m_axis_tready,
        input  m_axis_tlast
    );

endinterface
`default_nettype wire

// File: rtl/ets_frame_packer.sv
`default_nettype none
// ============================================================================
//  Module      : ets_frame_packer
//  Description : Collects frame_len samples from the ETS sampling core into a
//                small FIFO and emits them as an AXI-Stream frame with tlast
//                on the final word. Abort or reset discards the frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module ets_frame_packer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] frame_len,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        frame_done,
    output logic        core_en,
    ets_frame_packer_if.master bus
);

    localparam int              c_aw       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_aw:0]   c_depth    = (c_aw + 1)'(FIFO_DEPTH);

    localparam logic [1:0]      c_st_idle  = 2'd0;
    localparam logic [1:0]      c_st_run   = 2'd1;
    localparam logic [1:0]      c_st_drain = 2'd2;

    logic [1:0]            r_state;
    logic [15:0]           r_len;
    logic [15:0]           r_cnt;
    logic                  r_frame_done;

    logic [31:0]           r_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_tag;
    logic [c_aw:0]         r_wptr;
    logic [c_aw:0]         r_rptr;

    logic [c_aw:0]         w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_s_ready;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_push_last;
    logic                  w_head_tag;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_count     = r_wptr - r_rptr;
    assign w_full      = (w_count == c_depth);
    assign w_empty     = (r_wptr == r_rptr);
    assign w_head_tag  = r_tag[r_rptr[c_aw-1:0]];

    // Readiness depends only on registered state, never on tready.
    assign w_s_ready   = (r_state == c_st_run) && !w_full && (r_cnt < r_len);
    assign w_push      = w_s_ready && bus.s_valid;
    assign w_pop       = !w_empty && bus.m_axis_tready;
    assign w_push_last = ((r_cnt + 16'd1) == r_len);

    assign busy              = (r_state != c_st_idle);
    assign core_en           = (r_state == c_st_run);
    assign frame_done        = r_frame_done;
    assign bus.s_ready       = w_s_ready;
    assign bus.m_axis_tvalid = !w_empty;
    assign bus.m_axis_tdata  = w_empty ? 32'd0 : r_data[r_rptr[c_aw-1:0]];
    assign bus.m_axis_tlast  = !w_empty && w_head_tag;

    // Frame control: start latching, sample counting, drain completion, abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_len        <= 16'd0;
            r_cnt        <= 16'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (abort) begin
                r_state <= c_st_idle;
                r_cnt   <= 16'd0;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (start && (frame_len != 16'd0)) begin
                            r_len   <= frame_len;
                            r_cnt   <= 16'd0;
                            r_state <= c_st_run;
                        end
                    end
                    c_st_run: begin
                        if (w_push) begin
                            r_cnt <= r_cnt + 16'd1;
                            if (w_push_last) begin
                                r_state <= c_st_drain;
                            end
                        end
                    end
                    c_st_drain: begin
                        if (w_pop && w_head_tag) begin
                            r_frame_done <= 1'b1;
                            r_state      <= c_st_idle;
                        end
                    end
                    default: begin
                        r_state <= c_st_idle;
                    end
                endcase
            end
        end
    end

    // FIFO pointers; reset and abort both discard everything buffered.
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wptr[c_aw-1:0]] <= bus.s_data;
            r_tag[r_wptr[c_aw-1:0]]  <= w_push_last;
        end
    end

endmodule
`default_nettype wire

// File: doc/ets_frame_packer.md
ETS_FRAME_PACKER -- requirements
Module: ets_frame_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning output buffer depth in words; legal values are powers of two, 2 to 16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port frame_len, input, 16 bits: samples per frame, sampled on start acceptance.
REQ-005 SHALL have port start, input, 1 bit: single-cycle frame request.
REQ-006 SHALL have port abort, input, 1 bit: terminates the current frame.
REQ-007 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-008 SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last word of a frame leaves.
REQ-009 SHALL have port core_en, output, 1 bit: enable to the upstream ETS sampling core.
REQ-010 SHALL have port s_data, input, 32 bits: accumulated sample from the ETS core.
REQ-011 SHALL have port s_valid, input, 1 bit: s_data is valid.
REQ-012 SHALL have port s_ready, output, 1 bit: the packer accepts s_data this cycle.
REQ-013 SHALL have port m_axis_tdata, output, 32 bits: stream data.
REQ-014 SHALL have port m_axis_tvalid, output, 1 bit: stream valid.
REQ-015 SHALL have port m_axis_tready, input, 1 bit: stream ready.
REQ-016 SHALL have port m_axis_tlast, output, 1 bit: marks the last word of a frame.

Function
REQ-017 SHALL implement the states IDLE, RUN and DRAIN.
REQ-018 IDLE: when start=1 and frame_len!=0, SHALL latch frame_len, clear the accept counter and go to RUN the next cycle; start with frame_len=0 is ignored.
REQ-019 start SHALL be ignored while busy=1.
REQ-020 RUN: core_en SHALL be 1; s_ready SHALL be (FIFO not full) AND (accept count < latched frame_len).
REQ-021 A sample SHALL be accepted when s_valid AND s_ready: push s_data to the FIFO and increment the counter (16-bit, no wrap, since it never exceeds frame_len).
REQ-022 The frame_len-th accepted word SHALL be stored with its last tag set; all other words have the tag cleared.
REQ-023 On the cycle the last word is accepted, the next state SHALL be DRAIN, and core_en and s_ready SHALL be 0 from the next cycle.
REQ-024 DRAIN: s_ready and core_en SHALL be 0; on the handshake (tvalid AND tready) of the tagged word, SHALL pulse frame_done for one cycle and go to IDLE the next cycle.
REQ-025 FIFO full: s_ready SHALL be 0. A pop in the same cycle does not enable a push (no combinational tready-to-s_ready path).
REQ-026 Simultaneous push and pop when the FIFO is not full SHALL keep the occupancy unchanged.
REQ-027 Latency: a word accepted in cycle N SHALL be presented on m_axis with tvalid=1 no earlier than N+1, and at N+1 if the FIFO was empty.
REQ-028 While tvalid=1 and tready=0, tdata and tlast SHALL be held stable.
REQ-029 m_axis_tvalid SHALL equal FIFO non-empty; m_axis_tlast SHALL equal the tag of the head word.
REQ-030 Words SHALL leave in acceptance order with no loss or duplication; occupancy never exceeds FIFO_DEPTH.
REQ-031 abort=1 in any state SHALL, at the next edge, flush the FIFO, clear the counter, enter IDLE, and produce no frame_done.
REQ-032 abort SHALL take priority over start and over any handshake in the same cycle.
REQ-033 The frame_len input SHALL be ignored after latching; a change mid-frame has no effect.

Reset
REQ-034 While reset=1, at the clock edge SHALL force: state IDLE, FIFO empty, counter 0, busy=0, frame_done=0, core_en=0, s_ready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
REQ-035 reset mid-frame SHALL discard all buffered words, and no frame_done SHALL follow.
REQ-036 reset SHALL dominate abort and start.

Verification
REQ-037 frame_len=3, s_valid held at 1, tready=1, data 0xA,0xB,0xC -> m_axis emits A,B,C; tlast only on C; frame_done pulses one cycle after C's handshake; busy then 0.
REQ-038 frame_len=8, FIFO_DEPTH=4, tready=0 -> exactly 4 accepts, then s_ready=0; raising tready drains in order; all 8 words are delivered; tlast on the 8th.
REQ-039 start with frame_len=0 -> stays in IDLE; busy, core_en and s_ready remain 0.
REQ-040 abort after 2 of 5 accepts with 2 words buffered -> next cycle tvalid=0, busy=0, no frame_done; a new start runs cleanly.
REQ-041 reset asserted during DRAIN with 3 words buffered -> all outputs at reset values the next cycle; no further tvalid.
REQ-042 start pulsed again during RUN with frame_len changed 4->9 -> ignored; the frame completes at 4 words.
